// File: rtl/fma_rr_arbiter.sv
// fma_rr_arbiter
// Shares one external FP32 FMA between N_REQ requesters. A combinational
// round-robin arbiter issues at most one operation per cycle. The winner's id
// travels through a tag pipe that matches the FMA latency, and the result is
// steered into that requester's response register. Each requester may have
// only one operation outstanding (issued but not yet popped).
// Optional feature: define FMA_ARB_PERF_EN to add the saturating counters
// perf_issued and perf_blocked.
module fma_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FMA_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ*32-1:0]   req_c,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [N_REQ*32-1:0]   rsp_data,
    output logic [31:0]           fma_a,
    output logic [31:0]           fma_b,
    output logic [31:0]           fma_c,
    output logic                  fma_issue,
    input  logic [31:0]           fma_result,
    output logic                  busy
`ifdef FMA_ARB_PERF_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_blocked
`endif
);

    localparam int             IDW     = $clog2(N_REQ);
    localparam logic [IDW:0]   N_REQ_W = N_REQ[IDW:0];

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [N_REQ-1:0] outstanding;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] rot;
    logic             grant_any;
    logic [IDW-1:0]   offset;
    logic [IDW:0]     win_sum;
    logic [IDW:0]     nxt_sum;
    logic [IDW-1:0]   win_id;
    logic             retire_valid;
    logic [IDW-1:0]   retire_id;

    // A requester with an operation still outstanding is not eligible.
    assign eligible = req_valid & ~outstanding;
    assign pop      = rsp_valid & rsp_ready;
    assign busy     = |outstanding;

    // Round-robin search: rotate so ptr sits at bit 0, take the lowest set bit, then map back modulo N_REQ
    always_comb begin
        rot       = N_REQ'({eligible, eligible} >> ptr);
        grant_any = 1'b0;
        offset    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_any = 1'b1;
                offset    = IDW'(k);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, offset};
        if (win_sum >= N_REQ_W) begin
            win_sum = win_sum - N_REQ_W;
        end
        win_id  = win_sum[IDW-1:0];
        nxt_sum = {1'b0, win_id} + 1'b1;
        if (nxt_sum == N_REQ_W) begin
            nxt_sum = '0;
        end
        ptr_next = nxt_sum[IDW-1:0];
    end

    // One-hot grant. It is held low while reset is asserted, so no request can be accepted during reset.
    always_comb begin
        req_ready = '0;
        if (grant_any && !rst) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign fma_issue = |req_ready;

    // Drive the winner's operands to the FMA. All operands are zero when nothing is issued.
    always_comb begin
        fma_a = '0;
        fma_b = '0;
        fma_c = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_ready[k]) begin
                fma_a = req_a[32*k +: 32];
                fma_b = req_b[32*k +: 32];
                fma_c = req_c[32*k +: 32];
            end
        end
    end

    // With no grant the pointer holds. Otherwise it moves to the requester just after the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (fma_issue) begin
            ptr <= ptr_next;
        end
    end

    generate
        if (FMA_LAT == 0) begin : g_no_pipe
            assign retire_valid = fma_issue;
            assign retire_id    = win_id;
        end else begin : g_pipe
            logic [FMA_LAT-1:0] tag_valid;
            logic [IDW-1:0]     tag_id [FMA_LAT];

            // Carry {valid, id} alongside the FMA stages. Reset drops every in-flight tag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid <= '0;
                    for (int s = 0; s < FMA_LAT; s++) begin
                        tag_id[s] <= '0;
                    end
                end else begin
                    tag_valid[0] <= fma_issue;
                    tag_id[0]    <= win_id;
                    for (int s = 1; s < FMA_LAT; s++) begin
                        tag_valid[s] <= tag_valid[s-1];
                        tag_id[s]    <= tag_id[s-1];
                    end
                end
            end

            assign retire_valid = tag_valid[FMA_LAT-1];
            assign retire_id    = tag_id[FMA_LAT-1];
        end
    endgenerate

    // Credit flags and response registers. A grant sets the credit flag, a pop clears it, and a retiring result fills its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
        end else begin
            outstanding <= (outstanding | req_ready) & ~pop;
            rsp_valid   <= rsp_valid & ~pop;
            for (int k = 0; k < N_REQ; k++) begin
                if (retire_valid && (retire_id == IDW'(k))) begin
                    rsp_valid[k]          <= 1'b1;
                    rsp_data[32*k +: 32]  <= fma_result;
                end
            end
        end
    end

    // The credit rule means a result never retires into a slot that is still holding an unpopped result.
    always @(posedge clk) begin
        if (!rst && retire_valid) begin
            assert (!rsp_valid[retire_id]);
        end
    end

`ifdef FMA_ARB_PERF_EN
    // Saturating counters: operations issued, and cycles where a request waited only because its credit was in use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued  <= '0;
            perf_blocked <= '0;
        end else begin
            if (fma_issue && (perf_issued != 32'hFFFF_FFFF)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((|(req_valid & outstanding)) && !fma_issue && (perf_blocked != 32'hFFFF_FFFF)) begin
                perf_blocked <= perf_blocked + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fma_rr_arbiter.sv
// tb_fma_rr_arbiter
// Four arbiter instances (N_REQ=4) with FMA_LAT = 0, 1, 2, 3. Instance g uses
// FMA_LAT = g, and each one is paired with a behavioural RNE FMA model.
module tb_fma_rr_arbiter;

    localparam int N  = 4;
    localparam int NI = 4;

    typedef struct {
        int          inst;
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_r;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid  [NI];
    logic [N-1:0]    req_ready  [NI];
    logic [N*32-1:0] req_a      [NI];
    logic [N*32-1:0] req_b      [NI];
    logic [N*32-1:0] req_c      [NI];
    logic [N-1:0]    rsp_valid  [NI];
    logic [N-1:0]    rsp_ready  [NI];
    logic [N*32-1:0] rsp_data   [NI];
    logic [31:0]     fma_a      [NI];
    logic [31:0]     fma_b      [NI];
    logic [31:0]     fma_c      [NI];
    logic            fma_issue  [NI];
    logic [31:0]     fma_result [NI];
    logic            busy       [NI];
`ifdef FMA_ARB_PERF_EN
    logic [31:0]     perf_issued  [NI];
    logic [31:0]     perf_blocked [NI];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs [9];

    // Reference FMA: any NaN input gives the canonical NaN. Otherwise the operation is done in double precision and rounded to FP32 with RNE.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [31:0] base;
        int          e;
        if (r == 0.0) return 32'h0;
        d    = $realtobits(r);
        e    = int'(d[62:52]) - 896;
        base = {d[63], 8'(e), d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || d[29])) base = base + 32'd1;
        return base;
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (is_nan(a) || is_nan(b) || is_nan(c)) return 32'h7FC0_0000;
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fma_rr_arbiter #(.N_REQ(N), .FMA_LAT(g)) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .req_c      (req_c[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .fma_a      (fma_a[g]),
            .fma_b      (fma_b[g]),
            .fma_c      (fma_c[g]),
            .fma_issue  (fma_issue[g]),
            .fma_result (fma_result[g]),
            .busy       (busy[g])
`ifdef FMA_ARB_PERF_EN
            ,
            .perf_issued  (perf_issued[g]),
            .perf_blocked (perf_blocked[g])
`endif
        );

        if (g == 0) begin : g_comb_fma
            assign fma_result[g] = fma_ref(fma_a[g], fma_b[g], fma_c[g]);
        end else begin : g_pipe_fma
            logic [31:0] pipe [g];
            // FMA model with g register stages. It has no reset, so stale results can still reach the arbiter after a reset.
            always @(posedge clk) begin
                pipe[0] <= fma_ref(fma_a[g], fma_b[g], fma_c[g]);
                for (int j = 1; j < g; j++) pipe[j] <= pipe[j-1];
            end
            assign fma_result[g] = pipe[g-1];
        end
    end

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int k, input logic [N-1:0] valid, input int id,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        req_valid[k]          = valid;
        req_a[k][32*id +: 32] = a;
        req_b[k][32*id +: 32] = b;
        req_c[k][32*id +: 32] = c;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = '0;
            rsp_ready[k] = '0;
            req_a[k]     = '0;
            req_b[k]     = '0;
            req_c[k]     = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{0, 2, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h40E0_0000};
        vecs[1] = '{0, 1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3E80_0000, 32'h4020_0000};
        vecs[2] = '{1, 3, 32'hC000_0000, 32'h4080_0000, 32'h3F80_0000, 32'hC0E0_0000};
        vecs[3] = '{1, 0, 32'h7F80_0001, 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000};
        vecs[4] = '{1, 2, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
        vecs[5] = '{2, 1, 32'h3F80_0001, 32'h3FC0_0000, 32'h0000_0000, 32'h3FC0_0002};
        vecs[6] = '{2, 3, 32'h3F80_0001, 32'h3F80_0001, 32'h0000_0000, 32'h3F80_0002};
        vecs[7] = '{3, 0, 32'h3F80_0003, 32'h3FC0_0000, 32'h0000_0000, 32'h3FC0_0004};
        vecs[8] = '{3, 2, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h40E0_0000};

        $display("[TB] starting");

        // Reset state. Requests and pops are active here, but nothing may be accepted.
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = '1;
            rsp_ready[k] = '1;
            req_a[k]     = '1;
            req_b[k]     = '1;
            req_c[k]     = '1;
        end
        @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("rst%0d_ready", k), req_ready[k], 0);
            checkOutput($sformatf("rst%0d_issue_fma_a", k), {fma_issue[k], fma_a[k]}, 0);
            checkOutput($sformatf("rst%0d_rsp_valid_busy", k), {busy[k], rsp_valid[k]}, 0);
            checkOutput($sformatf("rst%0d_rsp_data_lo", k), rsp_data[k][63:0], 0);
        end
        doReset();

        // Table-driven single operations on each latency
        for (int v = 0; v < 9; v++) begin
            int           k;
            int           id;
            logic [N-1:0] onehot;
            k      = vecs[v].inst;
            id     = vecs[v].id;
            onehot = 4'b0001 << id;
            applyStimulus(k, onehot, id, vecs[v].a, vecs[v].b, vecs[v].c);
            checkOutput($sformatf("v%0d_grant", v), req_ready[k], onehot);
            checkOutput($sformatf("v%0d_fma_abc", v), {fma_a[k], fma_c[k]}, {vecs[v].a, vecs[v].c});
            cyc();
            req_valid[k] = '0;
            #1;
            checkOutput($sformatf("v%0d_idle_issue", v), {fma_issue[k], fma_a[k]}, 0);
            for (int t = 0; t < k; t++) begin
                checkOutput($sformatf("v%0d_rsp_early%0d", v, t), rsp_valid[k], 0);
                cyc();
            end
            checkOutput($sformatf("v%0d_rsp_valid", v), rsp_valid[k], onehot);
            checkOutput($sformatf("v%0d_rsp_data", v), rsp_data[k][32*id +: 32], vecs[v].exp_r);
            checkOutput($sformatf("v%0d_busy_held", v), busy[k], 1);
            rsp_ready[k] = onehot;
            cyc();
            rsp_ready[k] = '0;
            #1;
            checkOutput($sformatf("v%0d_popped", v), {busy[k], rsp_valid[k]}, 0);
        end

        // Round robin with all four requesters valid and immediate pops (FMA_LAT=0)
        doReset();
        for (int r = 0; r < N; r++)
            applyStimulus(0, 4'hF, r, 32'h3F80_0000, 32'h3F80_0000 + (32'(r) << 23), 32'h0);
        rsp_ready[0] = 4'hF;
        #1;
        for (int t = 0; t < 8; t++) begin
            checkOutput($sformatf("rr_grant%0d", t), req_ready[0], 4'b0001 << (t % 4));
            checkOutput($sformatf("rr_fma_b%0d", t), fma_b[0], 32'h3F80_0000 + (32'(t % 4) << 23));
            cyc();
        end
        req_valid[0] = '0;
        cyc();
        rsp_ready[0] = '0;
        #1;
        checkOutput("rr_drained", {busy[0], rsp_valid[0]}, 0);
`ifdef FMA_ARB_PERF_EN
        checkOutput("rr_perf", {perf_issued[0], perf_blocked[0]}, {32'd8, 32'd0});
`endif

        // FMA_LAT=3: requester 1 is stalled by its credit until its response pops
        doReset();
        applyStimulus(3, 4'b0010, 1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
        checkOutput("l3_grant1", req_ready[3], 4'b0010);
        cyc();
        applyStimulus(3, 4'b0010, 1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3E80_0000);
        for (int t = 0; t < 3; t++) begin
            checkOutput($sformatf("l3_stall%0d", t), {req_ready[3], rsp_valid[3]}, 0);
            cyc();
        end
        checkOutput("l3_rsp1_valid", rsp_valid[3], 4'b0010);
        checkOutput("l3_rsp1_data", rsp_data[3][63:32], 32'h40E0_0000);
        checkOutput("l3_held_stall", req_ready[3], 0);
        for (int t = 0; t < 2; t++) begin
            cyc();
            checkOutput($sformatf("l3_hold%0d", t), req_ready[3], 0);
        end
        rsp_ready[3] = 4'b0010;
        #1;
        checkOutput("l3_pop_cycle_no_grant", req_ready[3], 0);
        cyc();
        rsp_ready[3] = '0;
        #1;
        checkOutput("l3_grant2", {req_ready[3], rsp_valid[3]}, {4'b0010, 4'b0000});
`ifdef FMA_ARB_PERF_EN
        checkOutput("l3_perf_blocked", perf_blocked[3], 6);
        checkOutput("l3_perf_issued1", perf_issued[3], 1);
`endif
        cyc();
        req_valid[3] = '0;
        #1;
        for (int t = 0; t < 3; t++) begin
            checkOutput($sformatf("l3_rsp2_early%0d", t), rsp_valid[3], 0);
            cyc();
        end
        checkOutput("l3_rsp2_valid", rsp_valid[3], 4'b0010);
        checkOutput("l3_rsp2_data", rsp_data[3][63:32], 32'h4020_0000);
`ifdef FMA_ARB_PERF_EN
        checkOutput("l3_perf_issued2", perf_issued[3], 2);
`endif
        rsp_ready[3] = 4'b0010;
        cyc();
        rsp_ready[3] = '0;
        #1;
        checkOutput("l3_idle", busy[3], 0);

        // FMA_LAT=2: reset is asserted while two operations are in flight
        doReset();
        applyStimulus(2, 4'b0011, 0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
        applyStimulus(2, 4'b0011, 1, 32'hC000_0000, 32'h4080_0000, 32'h3F80_0000);
        checkOutput("l2_grant0", req_ready[2], 4'b0001);
        cyc();
        checkOutput("l2_grant1", req_ready[2], 4'b0010);
        cyc();
        req_valid[2] = 4'b0011;
        #1;
        checkOutput("l2_inflight_busy", {busy[2], rsp_valid[2]}, {1'b1, 4'b0000});
        rst = 1'b1;
        #1;
        checkOutput("l2_async_busy", busy[2], 0);
        checkOutput("l2_async_ready", {fma_issue[2], req_ready[2]}, 0);
        @(posedge clk);
        #2;
        req_valid[2] = '0;
        rst          = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            checkOutput($sformatf("l2_no_stale%0d", t), {busy[2], rsp_valid[2]}, 0);
            cyc();
        end
        applyStimulus(2, 4'b0110, 2, 32'h0, 32'h0, 32'h0);
        checkOutput("l2_ptr_reset", req_ready[2], 4'b0010);

        // FMA_LAT=1: requesters 0 and 3 issue back to back, and each result must land only in its own slot
        doReset();
        applyStimulus(1, 4'b1001, 0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
        applyStimulus(1, 4'b1001, 3, 32'hC000_0000, 32'h4080_0000, 32'h3F80_0000);
        checkOutput("l1_grant0", req_ready[1], 4'b0001);
        cyc();
        checkOutput("l1_grant3", req_ready[1], 4'b1000);
        checkOutput("l1_fma_a3", fma_a[1], 32'hC000_0000);
        cyc();
        req_valid[1] = '0;
        #1;
        checkOutput("l1_rsp0_valid", rsp_valid[1], 4'b0001);
        checkOutput("l1_slots_a", {rsp_data[1][31:0], rsp_data[1][127:96]}, {32'h40E0_0000, 32'h0});
        cyc();
        checkOutput("l1_rsp3_valid", rsp_valid[1], 4'b1001);
        checkOutput("l1_slots_b", {rsp_data[1][31:0], rsp_data[1][127:96]}, {32'h40E0_0000, 32'hC0E0_0000});
        checkOutput("l1_slots_untouched", rsp_data[1][95:32], 0);
        rsp_ready[1] = 4'b1001;
        cyc();
        rsp_ready[1] = '0;
        #1;
        checkOutput("l1_idle", {busy[1], rsp_valid[1]}, 0);

        // FMA_LAT=0: pop of requester 0 in the same cycle as a retire to requester 1
        doReset();
        applyStimulus(0, 4'b0001, 0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
        checkOutput("co_grant0", req_ready[0], 4'b0001);
        cyc();
        checkOutput("co_rsp0", rsp_valid[0], 4'b0001);
        applyStimulus(0, 4'b0010, 1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3E80_0000);
        rsp_ready[0] = 4'b0001;
        #1;
        checkOutput("co_grant1", req_ready[0], 4'b0010);
        cyc();
        req_valid[0] = '0;
        rsp_ready[0] = '0;
        #1;
        checkOutput("co_rsp_after", rsp_valid[0], 4'b0010);
        checkOutput("co_data", {rsp_data[0][63:32], rsp_data[0][31:0]}, {32'h4020_0000, 32'h40E0_0000});
        req_valid[0] = 4'b0010;
        rsp_ready[0] = 4'b0010;
        #1;
        checkOutput("co_pop_req_same", req_ready[0], 0);
        cyc();
        rsp_ready[0] = '0;
        #1;
        checkOutput("co_regrant", {req_ready[0], rsp_valid[0]}, {4'b0010, 4'b0000});
        cyc();
        req_valid[0] = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
